// File: rtl/sci_calc_seq.sv
// sci_calc_seq: multi-cycle unsigned calculator on an internal accumulator (ADD/SUB/MUL/DIV/SQR/CUBE/FACT/CLR).
// Latency: 1 edge for ADD/SUB/CLR/DIV-by-0/FACT n<=1, RW+1 for MUL/SQR/DIV, 2*RW+1 for CUBE, (n-1)*RW+1 for FACT.
// Backpressure: start is only honoured while busy=0; a start during an operation is dropped, never queued.
module sci_calc_seq #(
  parameter int W  = 8,
  parameter int RW = 16
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  input  logic [2:0]    op,
  input  logic          chain,
  input  logic [W-1:0]  A,
  input  logic [W-1:0]  B,
  output logic          busy,
  output logic          done,
  output logic [RW-1:0] result,
  output logic          ovf,
  output logic          neg,
  output logic          dz
);

  localparam int CW = $clog2(RW);

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_MUL  = 3'd2;
  localparam logic [2:0] OP_DIV  = 3'd3;
  localparam logic [2:0] OP_SQR  = 3'd4;
  localparam logic [2:0] OP_CUBE = 3'd5;
  localparam logic [2:0] OP_FACT = 3'd6;

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t         state;
  logic [2:0]     op_q;
  logic [RW-1:0]  lft;        // latched left operand, reused as the CUBE second multiplier
  logic [CW-1:0]  cnt;        // bit index within the current MUL pass / DIV run
  logic           cube_2nd;   // CUBE is on its second pass
  logic [3:0]     fact_k;     // FACT multiplier of the current pass
  logic [3:0]     fact_n;

  // shift-add multiplier: running partial product with a full-width view for overflow
  logic [2*RW-1:0] mul_sh;
  logic [2*RW-1:0] mul_p;
  logic [RW-1:0]   mul_b;

  // restoring divider: remainder stays below the divisor so RW bits suffice
  logic [RW-1:0]  rem;
  logic [RW-1:0]  quo;
  logic [RW-1:0]  dvs;

  logic [RW-1:0]   l_in;
  logic [RW-1:0]   b_in;
  logic [RW:0]     sum_ext;
  logic [2*RW-1:0] mul_p_nxt;
  logic            mul_hi_nz;
  logic [RW:0]     rem_sh;
  logic [RW:0]     div_diff;
  logic [RW-1:0]   quo_nxt;
  logic [RW-1:0]   rem_nxt;
  logic            last;

  // operand selection and one iteration of the multiply / divide datapaths
  always_comb begin
    l_in      = chain ? result : {{(RW-W){1'b0}}, A};
    b_in      = {{(RW-W){1'b0}}, B};
    sum_ext   = {1'b0, l_in} + {1'b0, b_in};
    mul_p_nxt = mul_b[0] ? (mul_p + mul_sh) : mul_p;
    mul_hi_nz = |mul_p_nxt[2*RW-1:RW];
    rem_sh    = {rem, quo[RW-1]};
    div_diff  = rem_sh - {1'b0, dvs};
    // MSB of the difference is the borrow: remainder shifted in was below the divisor
    if (div_diff[RW]) begin
      rem_nxt = rem_sh[RW-1:0];
      quo_nxt = {quo[RW-2:0], 1'b0};
    end else begin
      rem_nxt = div_diff[RW-1:0];
      quo_nxt = {quo[RW-2:0], 1'b1};
    end
    last = (cnt == CW'(RW-1));
  end

  // control FSM with registered handshake outputs, accumulator and flags
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
      ovf      <= 1'b0;
      neg      <= 1'b0;
      dz       <= 1'b0;
      op_q     <= '0;
      lft      <= '0;
      cnt      <= '0;
      cube_2nd <= 1'b0;
      fact_k   <= '0;
      fact_n   <= '0;
      mul_sh   <= '0;
      mul_p    <= '0;
      mul_b    <= '0;
      rem      <= '0;
      quo      <= '0;
      dvs      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            busy     <= 1'b1;
            ovf      <= 1'b0;
            neg      <= 1'b0;
            dz       <= 1'b0;
            op_q     <= op;
            lft      <= l_in;
            cnt      <= '0;
            cube_2nd <= 1'b0;
            mul_p    <= '0;
            case (op)
              OP_ADD: begin
                result <= sum_ext[RW-1:0];
                ovf    <= sum_ext[RW];
                state  <= DONE;
                done   <= 1'b1;
              end
              OP_SUB: begin
                result <= l_in - b_in;
                neg    <= (l_in < b_in);
                state  <= DONE;
                done   <= 1'b1;
              end
              OP_MUL: begin
                mul_sh <= {{RW{1'b0}}, l_in};
                mul_b  <= b_in;
                state  <= MUL;
              end
              OP_DIV: begin
                if (b_in == '0) begin
                  result <= '1;
                  dz     <= 1'b1;
                  state  <= DONE;
                  done   <= 1'b1;
                end else begin
                  rem   <= '0;
                  quo   <= l_in;
                  dvs   <= b_in;
                  state <= DIV;
                end
              end
              OP_SQR, OP_CUBE: begin
                mul_sh <= {{RW{1'b0}}, l_in};
                mul_b  <= l_in;
                state  <= MUL;
              end
              OP_FACT: begin
                if (l_in[3:0] <= 4'd1) begin
                  result <= {{(RW-1){1'b0}}, 1'b1};
                  state  <= DONE;
                  done   <= 1'b1;
                end else begin
                  // first pass forms 1*2, later passes multiply by 3..n
                  mul_sh <= {{(2*RW-1){1'b0}}, 1'b1};
                  mul_b  <= {{(RW-2){1'b0}}, 2'd2};
                  fact_k <= 4'd2;
                  fact_n <= l_in[3:0];
                  state  <= MUL;
                end
              end
              default: begin
                result <= '0;
                state  <= DONE;
                done   <= 1'b1;
              end
            endcase
          end
        end
        MUL: begin
          mul_p  <= mul_p_nxt;
          mul_sh <= mul_sh << 1;
          mul_b  <= mul_b >> 1;
          cnt    <= cnt + CW'(1);
          if (last) begin
            ovf   <= ovf | mul_hi_nz;
            cnt   <= '0;
            mul_p <= '0;
            if (op_q == OP_CUBE && !cube_2nd) begin
              cube_2nd <= 1'b1;
              mul_sh   <= {{RW{1'b0}}, mul_p_nxt[RW-1:0]};
              mul_b    <= lft;
            end else if (op_q == OP_FACT && fact_k != fact_n) begin
              fact_k <= fact_k + 4'd1;
              mul_sh <= {{RW{1'b0}}, mul_p_nxt[RW-1:0]};
              mul_b  <= {{(RW-4){1'b0}}, fact_k + 4'd1};
            end else begin
              result <= mul_p_nxt[RW-1:0];
              state  <= DONE;
              done   <= 1'b1;
            end
          end
        end
        DIV: begin
          rem <= rem_nxt;
          quo <= quo_nxt;
          cnt <= cnt + CW'(1);
          if (last) begin
            result <= quo_nxt;
            state  <= DONE;
            done   <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sci_calc_seq.sv
// tb_sci_calc_seq: table vectors, hand sequences and random ops against an arithmetic model of sci_calc_seq.
// Latency: measured in edges from the accept edge to the first cycle with done=1.
// Backpressure: the bench only raises start while the DUT is idle, except where it deliberately tests a dropped start.
module tb_sci_calc_seq;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic        chain = 1'b0;
  logic [7:0]  A = 8'd0;
  logic [7:0]  B = 8'd0;
  logic        busy, done, ovf, neg, dz;
  logic [15:0] result;

  int n_cmp = 0;
  int n_bad = 0;
  logic [15:0] acc_m = 16'd0;

  sci_calc_seq #(.W(8), .RW(16)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .op(op), .chain(chain),
    .A(A), .B(B), .busy(busy), .done(done), .result(result),
    .ovf(ovf), .neg(neg), .dz(dz)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic        chain;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] res;
    logic        f_ovf;
    logic        f_neg;
    logic        f_dz;
    int          lat;
  } vec_t;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // arithmetic reference: exact results in 64 bits, then reduced mod 2^16
  task automatic model(input logic [2:0] o, input logic [15:0] l, input logic [7:0] b,
                       output logic [15:0] r, output logic fo, output logic fn,
                       output logic fd, output int lat);
    longint t;
    int n;
    t = 0; fo = 0; fn = 0; fd = 0; lat = 1; r = 16'd0;
    case (o)
      3'd0: t = longint'(l) + longint'(b);
      3'd1: t = 0;
      3'd2: begin t = longint'(l) * longint'(b); lat = 17; end
      3'd3: if (b != 0) begin t = longint'(l) / longint'(b); lat = 17; end
      3'd4: begin t = longint'(l) * longint'(l); lat = 17; end
      3'd5: begin t = longint'(l) * longint'(l) * longint'(l); lat = 33; end
      3'd6: begin
        n = int'(l[3:0]);
        t = 1;
        for (int k = 2; k <= n; k++) t = t * k;
        if (n >= 2) lat = (n - 1) * 16 + 1;
      end
      default: t = 0;
    endcase
    r  = t[15:0];
    fo = (t >= 64'd65536);
    if (o == 3'd1) begin
      r  = l - 16'(b);
      fn = (l < 16'(b));
    end
    if (o == 3'd3 && b == 0) begin
      r  = 16'hFFFF;
      fd = 1'b1;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    start   = 1'b0;
    @(posedge clk);
    #1 reset_n = 1'b1;
    acc_m = 16'd0;
  endtask

  // issue one op while idle and check result, flags, latency and the done pulse
  task automatic do_op(input string nm, input logic [2:0] o, input logic c,
                       input logic [7:0] a, input logic [7:0] b,
                       input logic [15:0] er, input logic eo, input logic en,
                       input logic ed, input int elat);
    int lat;
    bit got;
    @(negedge clk);
    op = o; chain = c; A = a; B = b; start = 1'b1;
    @(posedge clk);
    lat = 1;
    #1;
    start = 1'b0;
    op = 3'($urandom); chain = 1'($urandom); A = 8'($urandom); B = 8'($urandom);
    got = 0;
    while (!got && lat <= 400) begin
      @(negedge clk);
      if (done) got = 1;
      else begin
        @(posedge clk);
        lat++;
      end
    end
    if (!got) begin
      chk({nm, " timeout"}, 0, 1);
      do_reset();
    end else begin
      chk({nm, " result"}, result, er);
      chk({nm, " ovf"}, ovf, eo);
      chk({nm, " neg"}, neg, en);
      chk({nm, " dz"}, dz, ed);
      chk({nm, " latency"}, lat, elat);
      chk({nm, " busy@done"}, busy, 1);
      @(negedge clk);
      chk({nm, " done pulse width"}, done, 0);
      acc_m = er;
    end
  endtask

  initial begin
    vec_t vt[$];
    logic [15:0] r, l;
    logic fo, fn, fd;
    int lat, dcnt;
    logic [2:0] o;
    logic c;
    logic [7:0] a, b;

    vt.push_back('{3'd0, 1'b0, 8'd5,    8'd3,   16'd8,     1'b0, 1'b0, 1'b0, 1});
    vt.push_back('{3'd4, 1'b1, 8'd0,    8'd0,   16'd64,    1'b0, 1'b0, 1'b0, 17});
    vt.push_back('{3'd5, 1'b0, 8'd41,   8'd0,   16'd3385,  1'b1, 1'b0, 1'b0, 33});
    vt.push_back('{3'd3, 1'b0, 8'd200,  8'd7,   16'd28,    1'b0, 1'b0, 1'b0, 17});
    vt.push_back('{3'd3, 1'b0, 8'd9,    8'd0,   16'hFFFF,  1'b0, 1'b0, 1'b1, 1});
    vt.push_back('{3'd6, 1'b0, 8'd8,    8'd0,   16'd40320, 1'b0, 1'b0, 1'b0, 113});
    vt.push_back('{3'd6, 1'b0, 8'd9,    8'd0,   16'd35200, 1'b1, 1'b0, 1'b0, 129});
    vt.push_back('{3'd6, 1'b0, 8'd0,    8'd0,   16'd1,     1'b0, 1'b0, 1'b0, 1});
    vt.push_back('{3'd3, 1'b0, 8'd0,    8'd0,   16'hFFFF,  1'b0, 1'b0, 1'b1, 1});
    vt.push_back('{3'd1, 1'b0, 8'd3,    8'd5,   16'hFFFE,  1'b0, 1'b1, 1'b0, 1});
    vt.push_back('{3'd0, 1'b1, 8'd0,    8'd2,   16'd0,     1'b1, 1'b0, 1'b0, 1});
    vt.push_back('{3'd2, 1'b0, 8'd255,  8'd255, 16'd65025, 1'b0, 1'b0, 1'b0, 17});
    vt.push_back('{3'd3, 1'b1, 8'd0,    8'd255, 16'd255,   1'b0, 1'b0, 1'b0, 17});
    vt.push_back('{3'd7, 1'b1, 8'd77,   8'd12,  16'd0,     1'b0, 1'b0, 1'b0, 1});
    vt.push_back('{3'd6, 1'b0, 8'd1,    8'd0,   16'd1,     1'b0, 1'b0, 1'b0, 1});
    vt.push_back('{3'd6, 1'b0, 8'd2,    8'd0,   16'd2,     1'b0, 1'b0, 1'b0, 17});
    vt.push_back('{3'd6, 1'b0, 8'h13,   8'd0,   16'd6,     1'b0, 1'b0, 1'b0, 33});
    vt.push_back('{3'd1, 1'b1, 8'd0,    8'd6,   16'd0,     1'b0, 1'b0, 1'b0, 1});

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset result", result, 0);
    chk("reset flags", {ovf, neg, dz}, 0);
    reset_n = 1'b1;

    foreach (vt[i])
      do_op($sformatf("vec%0d", i), vt[i].op, vt[i].chain, vt[i].a, vt[i].b,
            vt[i].res, vt[i].f_ovf, vt[i].f_neg, vt[i].f_dz, vt[i].lat);

    // a start raised mid-MUL must be dropped: one done, MUL result kept
    @(negedge clk);
    op = 3'd2; chain = 1'b0; A = 8'd3; B = 8'd4; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    op = 3'd0; A = 8'd1; B = 8'd1; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    dcnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    chk("ignored start done count", dcnt, 1);
    chk("ignored start result", result, 12);
    acc_m = 16'd12;

    // reset during a MUL aborts it with no done
    @(negedge clk);
    op = 3'd2; chain = 1'b0; A = 8'd100; B = 8'd100; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("midreset busy", busy, 0);
    chk("midreset done", done, 0);
    chk("midreset result", result, 0);
    reset_n = 1'b1;
    acc_m = 16'd0;
    dcnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    chk("midreset no late done", dcnt, 0);
    do_op("post-reset add", 3'd0, 1'b0, 8'd7, 8'd9, 16'd16, 1'b0, 1'b0, 1'b0, 1);

    // random ops against the model, chaining through the model accumulator
    for (int i = 0; i < 60; i++) begin
      o = 3'($urandom);
      c = 1'($urandom);
      a = 8'($urandom);
      b = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
      l = c ? acc_m : {8'd0, a};
      model(o, l, b, r, fo, fn, fd, lat);
      do_op($sformatf("rand%0d op%0d", i, o), o, c, a, b, r, fo, fn, fd, lat);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
